// File: rtl/multdiv_stall_controller.sv
// multdiv_stall_controller
// Execute-stage sequencer for mul/div R-type instructions held in the DX latch.
// It freezes PC/FD/DX and bubbles XM while the multi-cycle multdiv unit runs,
// then presents a registered result and error flag for one DONE cycle, during
// which the instruction is released into XM with its result.
module multdiv_stall_controller #(
  parameter int unsigned MAX_CYCLES = 40,
  parameter logic [4:0]  MUL_ALU_OP = 5'd6,
  parameter logic [4:0]  DIV_ALU_OP = 5'd7
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] DX_Latch_Instr,
  input  logic        flush,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        pipeline_stall,
  output logic        XM_bubble,
  output logic        md_done,
  output logic [31:0] md_result_out,
  output logic        md_error_out,
  output logic [5:0]  busy_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // busy_count value of the last BUSY cycle allowed before a forced timeout
  localparam logic [5:0] LP_LAST_COUNT = 6'(MAX_CYCLES - 1);

  state_t      r_state;
  logic        r_ctrl_mult;
  logic        r_ctrl_div;
  logic        r_md_done;
  logic [31:0] r_md_result;
  logic        r_md_error;
  logic [5:0]  r_busy_count;

  logic [4:0]  w_opcode;
  logic [4:0]  w_alu_op;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_is_md;
  logic        w_stall;
  logic        w_unused;

  assign w_opcode = DX_Latch_Instr[31:27];
  assign w_alu_op = DX_Latch_Instr[6:2];
  assign w_is_mul = (w_opcode == 5'd0) && (w_alu_op == MUL_ALU_OP);
  assign w_is_div = (w_opcode == 5'd0) && (w_alu_op == DIV_ALU_OP);
  assign w_is_md  = w_is_mul || w_is_div;

  // Register fields (rd/rs/rt/shamt) play no part in the decode.
  assign w_unused = ^{DX_Latch_Instr[26:7], DX_Latch_Instr[1:0]};

  // Stall is gated by reset_n so an asserted reset forces every output low
  // even while a mul/div still sits in DX.
  assign w_stall = reset_n && !flush &&
                   (((r_state == S_IDLE) && w_is_md) || (r_state == S_BUSY));

  assign pipeline_stall = w_stall;
  assign XM_bubble      = w_stall;
  assign ctrl_MULT      = r_ctrl_mult;
  assign ctrl_DIV       = r_ctrl_div;
  assign md_done        = r_md_done;
  assign md_result_out  = r_md_result;
  assign md_error_out   = r_md_error;
  assign busy_count     = r_busy_count;

  // Sequencer FSM with registered start pulses, done strobe, result and counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_ctrl_mult  <= 1'b0;
      r_ctrl_div   <= 1'b0;
      r_md_done    <= 1'b0;
      r_md_result  <= '0;
      r_md_error   <= 1'b0;
      r_busy_count <= '0;
    end else begin
      r_ctrl_mult <= 1'b0;
      r_ctrl_div  <= 1'b0;
      r_md_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_is_md && !flush) begin
            r_state      <= S_BUSY;
            r_ctrl_mult  <= w_is_mul;
            r_ctrl_div   <= w_is_div;
            r_busy_count <= '0;
          end
        end
        S_BUSY: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (md_resultRDY) begin
            r_state     <= S_DONE;
            r_md_done   <= 1'b1;
            r_md_result <= md_exception ? '0 : md_result;
            r_md_error  <= md_exception;
          end else if (r_busy_count == LP_LAST_COUNT) begin
            r_state     <= S_DONE;
            r_md_done   <= 1'b1;
            r_md_result <= '0;
            r_md_error  <= 1'b1;
          end else if (r_busy_count != '1) begin
            r_busy_count <= r_busy_count + 6'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_stall_controller.sv
// Directed testbench for multdiv_stall_controller. Inputs change 1 ns after
// the rising edge; outputs are sampled on the falling edge.
module tb_multdiv_stall_controller;

  localparam logic [31:0] NOP_I     = 32'h0000_0000;
  localparam logic [31:0] MUL_I     = 32'h0062_0818; // opcode 0, ALU_op 6
  localparam logic [31:0] MUL_RD0_I = 32'h0002_0818; // mul with rd = 0
  localparam logic [31:0] DIV_I     = 32'h0062_081C; // opcode 0, ALU_op 7
  localparam logic [31:0] ADD_I     = 32'h0062_0800; // opcode 0, ALU_op 0
  localparam logic [31:0] OP5_I     = 32'h2800_0018; // opcode 5, ALU_op 6

  logic        clock;
  logic        reset_n;
  logic [31:0] DX_Latch_Instr;
  logic        flush;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        pipeline_stall;
  logic        XM_bubble;
  logic        md_done;
  logic [31:0] md_result_out;
  logic        md_error_out;
  logic [5:0]  busy_count;

  int n_pass;
  int n_total;

  multdiv_stall_controller #(
    .MAX_CYCLES(40),
    .MUL_ALU_OP(5'd6),
    .DIV_ALU_OP(5'd7)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .DX_Latch_Instr (DX_Latch_Instr),
    .flush          (flush),
    .md_result      (md_result),
    .md_exception   (md_exception),
    .md_resultRDY   (md_resultRDY),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .pipeline_stall (pipeline_stall),
    .XM_bubble      (XM_bubble),
    .md_done        (md_done),
    .md_result_out  (md_result_out),
    .md_error_out   (md_error_out),
    .busy_count     (busy_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    DX_Latch_Instr = MUL_I;
    flush = 1'b0; md_result = 32'h0; md_exception = 1'b0; md_resultRDY = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    n_total++;
    if ({ctrl_MULT, ctrl_DIV, md_done, md_error_out} !== 4'b0000) $display("FAIL reset_pulses got %b expected 0000", {ctrl_MULT, ctrl_DIV, md_done, md_error_out});
    else n_pass++;
    n_total++;
    if ({pipeline_stall, XM_bubble} !== 2'b00) $display("FAIL reset_stall got %b expected 00", {pipeline_stall, XM_bubble});
    else n_pass++;
    n_total++;
    if (md_result_out !== 32'h0) $display("FAIL reset_result got %h expected 00000000", md_result_out);
    else n_pass++;
    n_total++;
    if (busy_count !== 6'd0) $display("FAIL reset_busy_count got %0d expected 0", busy_count);
    else n_pass++;
    DX_Latch_Instr = NOP_I;
    tick;
    reset_n = 1'b1;
    @(negedge clock);
    n_total++;
    if (pipeline_stall !== 1'b0) $display("FAIL post_reset_stall got %b expected 0", pipeline_stall);
    else n_pass++;
  endtask

  task automatic test_decode;
    tick; DX_Latch_Instr = OP5_I;
    @(negedge clock);
    n_total++;
    if (pipeline_stall !== 1'b0) $display("FAIL decode_op5 got %b expected 0", pipeline_stall);
    else n_pass++;
    tick; DX_Latch_Instr = ADD_I;
    @(negedge clock);
    n_total++;
    if (pipeline_stall !== 1'b0) $display("FAIL decode_add got %b expected 0", pipeline_stall);
    else n_pass++;
    tick; DX_Latch_Instr = NOP_I;
    @(negedge clock);
    n_total++;
    if ({ctrl_MULT, ctrl_DIV} !== 2'b00) $display("FAIL decode_no_start got %b expected 00", {ctrl_MULT, ctrl_DIV});
    else n_pass++;
  endtask

  task automatic test_mul;
    int n_st;
    n_st = 0;
    tick; DX_Latch_Instr = MUL_I; md_resultRDY = 1'b0;
    @(negedge clock);
    n_total++;
    if ({pipeline_stall, XM_bubble, ctrl_MULT} !== 3'b110) $display("FAIL mul_issue got %b expected 110", {pipeline_stall, XM_bubble, ctrl_MULT});
    else n_pass++;
    if (pipeline_stall === 1'b1) n_st++;
    for (int i = 1; i <= 3; i++) begin
      tick;
      md_resultRDY = (i == 3);
      md_result    = (i == 3) ? 32'h0000_0C00 : 32'h0000_0000;
      @(negedge clock);
      n_total++;
      if (ctrl_MULT !== (i == 1)) $display("FAIL mul_pulse_b%0d got %b expected %b", i, ctrl_MULT, (i == 1));
      else n_pass++;
      n_total++;
      if (busy_count !== 6'(i - 1)) $display("FAIL mul_busy_count_b%0d got %0d expected %0d", i, busy_count, i - 1);
      else n_pass++;
      if (pipeline_stall === 1'b1) n_st++;
    end
    tick; md_resultRDY = 1'b0; md_result = 32'h0;
    @(negedge clock);
    n_total++;
    if (n_st !== 4) $display("FAIL mul_stall_cycles got %0d expected 4", n_st);
    else n_pass++;
    n_total++;
    if ({pipeline_stall, md_done, md_error_out} !== 3'b010) $display("FAIL mul_done_flags got %b expected 010", {pipeline_stall, md_done, md_error_out});
    else n_pass++;
    n_total++;
    if (md_result_out !== 32'h0000_0C00) $display("FAIL mul_result got %h expected 00000c00", md_result_out);
    else n_pass++;
    tick; DX_Latch_Instr = NOP_I;
    @(negedge clock);
    n_total++;
    if ({md_done, ctrl_MULT, pipeline_stall} !== 3'b000) $display("FAIL mul_after_done got %b expected 000", {md_done, ctrl_MULT, pipeline_stall});
    else n_pass++;
  endtask

  task automatic test_flush;
    tick; DX_Latch_Instr = MUL_I;
    @(negedge clock);
    tick;
    @(negedge clock);
    n_total++;
    if ({pipeline_stall, ctrl_MULT} !== 2'b11) $display("FAIL flush_busy1 got %b expected 11", {pipeline_stall, ctrl_MULT});
    else n_pass++;
    // flush together with RDY in BUSY cycle 2: flush must win
    tick; flush = 1'b1; md_resultRDY = 1'b1; md_result = 32'h0000_1234;
    @(negedge clock);
    n_total++;
    if ({pipeline_stall, XM_bubble} !== 2'b00) $display("FAIL flush_stall_drop got %b expected 00", {pipeline_stall, XM_bubble});
    else n_pass++;
    tick; flush = 1'b0; md_resultRDY = 1'b0; md_result = 32'h0; DX_Latch_Instr = NOP_I;
    @(negedge clock);
    n_total++;
    if ({md_done, pipeline_stall} !== 2'b00) $display("FAIL flush_no_done got %b expected 00", {md_done, pipeline_stall});
    else n_pass++;
    n_total++;
    if ({md_result_out, md_error_out} !== {32'h0000_0C00, 1'b0}) $display("FAIL flush_result_kept got %h/%b expected 00000c00/0", md_result_out, md_error_out);
    else n_pass++;
    // mul arriving together with flush in IDLE must not start
    tick; DX_Latch_Instr = MUL_I; flush = 1'b1;
    @(negedge clock);
    n_total++;
    if (pipeline_stall !== 1'b0) $display("FAIL flush_idle_stall got %b expected 0", pipeline_stall);
    else n_pass++;
    tick; DX_Latch_Instr = NOP_I; flush = 1'b0;
    @(negedge clock);
    n_total++;
    if ({ctrl_MULT, pipeline_stall, md_done} !== 3'b000) $display("FAIL flush_idle_no_start got %b expected 000", {ctrl_MULT, pipeline_stall, md_done});
    else n_pass++;
  endtask

  task automatic test_div_exception;
    int n_div;
    int n_mul;
    int n_st;
    n_div = 0; n_mul = 0; n_st = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      DX_Latch_Instr = (i < 4) ? DIV_I : NOP_I;
      md_resultRDY   = (i == 2);
      md_exception   = (i == 2);
      md_result      = 32'hDEAD_BEEF;
      @(negedge clock);
      if (ctrl_DIV === 1'b1) n_div++;
      if (ctrl_MULT === 1'b1) n_mul++;
      if (pipeline_stall === 1'b1) n_st++;
      if (i == 3) begin
        n_total++;
        if (md_done !== 1'b1) $display("FAIL div_done got %b expected 1", md_done);
        else n_pass++;
        n_total++;
        if ({md_result_out, md_error_out} !== {32'h0, 1'b1}) $display("FAIL div_exc_result got %h/%b expected 00000000/1", md_result_out, md_error_out);
        else n_pass++;
      end
    end
    md_exception = 1'b0; md_result = 32'h0;
    n_total++;
    if (n_div !== 1) $display("FAIL div_pulse_count got %0d expected 1", n_div);
    else n_pass++;
    n_total++;
    if (n_mul !== 0) $display("FAIL div_mult_pulses got %0d expected 0", n_mul);
    else n_pass++;
    n_total++;
    if (n_st !== 3) $display("FAIL div_stall_cycles got %0d expected 3", n_st);
    else n_pass++;
  endtask

  task automatic test_timeout;
    int n_st;
    int last_bc;
    bit seen;
    n_st = 0; last_bc = -1; seen = 1'b0;
    tick; DX_Latch_Instr = DIV_I; md_resultRDY = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (md_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (pipeline_stall === 1'b1) begin
        n_st++;
        last_bc = int'(busy_count);
      end
      tick;
    end
    n_total++;
    if (!seen) $display("FAIL timeout_done_seen got 0 expected 1 within 100 cycles");
    else n_pass++;
    n_total++;
    if (n_st !== 41) $display("FAIL timeout_stall_cycles got %0d expected 41", n_st);
    else n_pass++;
    n_total++;
    if (last_bc !== 39) $display("FAIL timeout_busy_count got %0d expected 39", last_bc);
    else n_pass++;
    n_total++;
    if ({md_result_out, md_error_out} !== {32'h0, 1'b1}) $display("FAIL timeout_result got %h/%b expected 00000000/1", md_result_out, md_error_out);
    else n_pass++;
    tick; DX_Latch_Instr = NOP_I;
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_stall;
    logic [7:0] exp_mult;
    logic [7:0] exp_done;
    logic [7:0] rdy_tab;
    int n_mul;
    int n_done;
    // bit i corresponds to cycle i
    exp_stall = 8'b0011_1011;
    exp_mult  = 8'b0001_0010;
    exp_done  = 8'b0100_0100;
    rdy_tab   = 8'b0010_0010;
    n_mul = 0; n_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      DX_Latch_Instr = (i < 7) ? MUL_I : NOP_I;
      md_resultRDY   = rdy_tab[i];
      md_result      = (i < 3) ? 32'h0000_0011 : 32'h0000_0022;
      @(negedge clock);
      n_total++;
      if (pipeline_stall !== exp_stall[i]) $display("FAIL b2b_stall_c%0d got %b expected %b", i, pipeline_stall, exp_stall[i]);
      else n_pass++;
      n_total++;
      if (ctrl_MULT !== exp_mult[i]) $display("FAIL b2b_mult_c%0d got %b expected %b", i, ctrl_MULT, exp_mult[i]);
      else n_pass++;
      n_total++;
      if (md_done !== exp_done[i]) $display("FAIL b2b_done_c%0d got %b expected %b", i, md_done, exp_done[i]);
      else n_pass++;
      if (ctrl_MULT === 1'b1) n_mul++;
      if (md_done === 1'b1) n_done++;
      if (i == 2) begin
        n_total++;
        if (md_result_out !== 32'h0000_0011) $display("FAIL b2b_result1 got %h expected 00000011", md_result_out);
        else n_pass++;
      end
      if (i == 6) begin
        n_total++;
        if (md_result_out !== 32'h0000_0022) $display("FAIL b2b_result2 got %h expected 00000022", md_result_out);
        else n_pass++;
      end
    end
    md_result = 32'h0;
    n_total++;
    if ({n_mul, n_done} !== {32'd2, 32'd2}) $display("FAIL b2b_counts got mul=%0d done=%0d expected 2/2", n_mul, n_done);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    tick; DX_Latch_Instr = MUL_RD0_I;
    @(negedge clock);
    tick;
    @(negedge clock);
    tick;
    @(negedge clock);
    n_total++;
    if ({pipeline_stall, busy_count} !== {1'b1, 6'd1}) $display("FAIL rst_mid_pre got %b/%0d expected 1/1", pipeline_stall, busy_count);
    else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_total++;
    if ({ctrl_MULT, ctrl_DIV, pipeline_stall, XM_bubble, md_done, md_error_out} !== 6'b0) $display("FAIL rst_mid_flags got %b expected 000000", {ctrl_MULT, ctrl_DIV, pipeline_stall, XM_bubble, md_done, md_error_out});
    else n_pass++;
    n_total++;
    if ({md_result_out, busy_count} !== 38'h0) $display("FAIL rst_mid_regs got %h/%0d expected 00000000/0", md_result_out, busy_count);
    else n_pass++;
    DX_Latch_Instr = NOP_I;
    tick;
    reset_n = 1'b1;
    tick; md_resultRDY = 1'b1; md_exception = 1'b1; md_result = 32'h0000_5555;
    @(negedge clock);
    tick; md_resultRDY = 1'b0; md_exception = 1'b0; md_result = 32'h0;
    @(negedge clock);
    n_total++;
    if ({md_done, md_error_out, md_result_out} !== 34'h0) $display("FAIL rst_spurious_rdy got %b/%b/%h expected 0/0/00000000", md_done, md_error_out, md_result_out);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset;
    test_decode;
    test_mul;
    test_flush;
    test_div_exception;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
